spi_mem_initiator: RTL and testbench
====================================

Name: spi_mem_initiator

Overview:
- Initiator end of the en/valid callback interface used by the SPI memory emulator.
- Accepts single read/write commands from a user-side valid/ready port and drives one memory access per command: mem_en, mem_wr_en, mem_addr, mem_wr_data.
- Waits for the responder's mem_valid, captures read data, and returns a response with a timeout error flag.
- Sits between the SPI command front-end and the memory model, or real flash later.

Parameters:
- ADDR_W, 6, address width of mem_addr/cmd_addr.
- DATA_W, 8, data width.
- TIMEOUT, 64, max cycles mem_en stays high waiting for mem_valid; valid range 2..2^16-1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  user command present.
- cmd_ready  output  1  block can accept command.
- cmd_wr  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_W  access address.
- cmd_wdata  input  DATA_W  write data.
- resp_valid  output  1  response present.
- resp_ready  input  1  user accepts response.
- resp_rdata  output  DATA_W  read data; 0 for writes and errors.
- resp_err  output  1  1 = access timed out.
- mem_en  output  1  access request to responder.
- mem_wr_en  output  1  access direction.
- mem_addr  output  ADDR_W  access address.
- mem_wr_data  output  DATA_W  write data.
- mem_rd_data  input  DATA_W  responder read data.
- mem_valid  input  1  responder completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0 (cmd_ready 0 during reset), state IDLE, timeout counter 0. Everything is registered.
- States: IDLE, REQ, REL, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cmd_wr, cmd_addr and cmd_wdata into mem_wr_en, mem_addr and mem_wr_data.
  - Set mem_en=1, clear the counter, go to REQ. mem_en rises the cycle after the handshake.
- REQ:
  - mem_en=1. mem_addr, mem_wr_en and mem_wr_data are held stable.
  - The counter increments each cycle.
  - If mem_valid=1: capture mem_rd_data into resp_rdata for reads (0 for writes), resp_err<=0, mem_en<=0, go to REL.
  - Else if counter==TIMEOUT-1: resp_rdata<=0, resp_err<=1, mem_en<=0, go to REL.
  - If mem_valid is seen on the timeout cycle, it wins (no error).
- REL:
  - mem_en=0. Wait for mem_valid==0, then go to RESP. No new access starts while mem_valid is high.
  - After a timeout, mem_valid is normally already 0, so REL lasts 1 cycle.
- RESP:
  - resp_valid=1 with stable resp_rdata/resp_err.
  - On resp_ready: resp_valid<=0, go to IDLE.
  - cmd_ready=0 in every state except IDLE, so commands arriving during REQ/REL/RESP stall.
- Ordering: strictly one outstanding access. Responses come back in command order.
- Latency: with the emulator responder (valid 8 clocks after en is sampled), the handshake-to-resp_valid time is about 11 cycles. The exact count depends on the responder; the bench checks ordering and values, not exact latency.
- Throughput: at least 1 idle cycle with mem_en=0 between consecutive accesses.
- Reset mid-operation: mem_en and resp_valid drop immediately (async) and the state returns to IDLE. Any in-flight response is lost.
- resp_ready may be held high permanently; RESP then lasts exactly 1 cycle.

Test Plan:
- Write 0xA5 to addr 0x2A, then read 0x2A, against the emulator -> write response has err=0 and rdata=0x00; read response has rdata=0xA5 and err=0; mem_addr is stable while mem_en=1.
- Hold cmd_valid=1 with two back-to-back reads (addr 0x01, 0x02) -> second mem_en rises only after mem_valid for the first has returned to 0; responses come back in order.
- mem_valid tied 0, TIMEOUT=16 -> mem_en is high for exactly 16 cycles, then resp_err=1 and resp_rdata=0x00; the next command proceeds normally once the responder is reconnected.
- resp_ready=0 for 5 cycles after resp_valid -> resp_valid, resp_rdata and resp_err are held constant and cmd_ready=0; acceptance in cycle 6 returns the block to IDLE.
- Assert rst_n=0 mid-REQ -> mem_en=0 and resp_valid=0 without waiting for a clock edge; after release, cmd_ready=1 and a read of 0x00 completes with err=0.
- mem_valid arrives on cycle TIMEOUT-1 -> normal response with err=0.

Source files
------------

// File: rtl/spi_mem_initiator.sv
// Initiator side of the en/valid memory callback: takes one user command at a time,
// drives a single mem_en access, and returns the read data or a timeout error.
module spi_mem_initiator #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_valid,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid and its payload stay stable until that edge.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  state_t            r_state;
  logic [15:0]       r_cnt;
  logic              r_cmd_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic              r_mem_en;
  logic              r_mem_wr_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wr_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cmd_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_err    <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_mem_wr_en   <= cmd_wr;
            r_mem_addr    <= cmd_addr;
            r_mem_wr_data <= cmd_wdata;
            r_mem_en      <= 1'b1;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b0;
            r_state       <= ST_REQ;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_REQ: begin
          // A completion on the final counted cycle still beats the timeout.
          if (mem_valid) begin
            r_resp_rdata <= r_mem_wr_en ? '0 : mem_rd_data;
            r_resp_err   <= 1'b0;
            r_mem_en     <= 1'b0;
            r_state      <= ST_REL;
          end else if (r_cnt == LP_LAST) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b1;
            r_mem_en     <= 1'b0;
            r_state      <= ST_REL;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_REL: begin
          if (!mem_valid) begin
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign mem_en      = r_mem_en;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_mem_initiator.sv
// Directed bench for spi_mem_initiator with an en/valid memory responder model,
// a response scoreboard and access-protocol monitors.
module tb_spi_mem_initiator;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       resp_valid, resp_ready, resp_err;
  logic [7:0] resp_rdata;
  logic       mem_en, mem_wr_en, mem_valid;
  logic [5:0] mem_addr;
  logic [7:0] mem_wr_data, mem_rd_data;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] exp_q[$];

  bit rsp_on    = 1'b1;
  int rsp_delay = 8;
  int rsp_cnt;
  logic [7:0] mem [64];

  logic       prev_en, prev_wr;
  logic [5:0] prev_addr;
  logic [7:0] prev_wd;
  int         en_cnt, last_en_len;
  logic [8:0] exp_v;

  spi_mem_initiator #(.ADDR_W(6), .DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_valid(mem_valid),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: raises mem_valid on the rsp_delay-th edge that samples mem_en high,
  // holds it until mem_en drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid   <= 1'b0;
      mem_rd_data <= 8'h00;
      rsp_cnt     <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h5A;
      mem[1] <= 8'h3C;
      mem[2] <= 8'hC3;
    end else if (mem_valid) begin
      if (!mem_en) begin
        mem_valid <= 1'b0;
        rsp_cnt   <= 0;
      end
    end else if (rsp_on && mem_en) begin
      if (rsp_cnt == rsp_delay - 1) begin
        mem_valid <= 1'b1;
        rsp_cnt   <= 0;
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        else           mem_rd_data   <= mem[mem_addr];
      end else begin
        rsp_cnt <= rsp_cnt + 1;
      end
    end else begin
      rsp_cnt <= 0;
    end
  end

  // Access monitor: request fields stable while mem_en is high, no new access
  // while mem_valid is still high, no command acceptance during an access.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
      en_cnt  = 0;
    end else begin
      if (mem_en && prev_en) begin
        check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
        check("mem_wr_en_stable", 32'(mem_wr_en), 32'(prev_wr));
        check("mem_wr_data_stable", 32'(mem_wr_data), 32'(prev_wd));
      end
      if (mem_en && !prev_en) check("en_rise_valid_low", 32'(mem_valid), 0);
      if (mem_en) begin
        check("cmd_ready_busy", 32'(cmd_ready), 0);
        en_cnt++;
      end else if (prev_en) begin
        last_en_len = en_cnt;
        en_cnt      = 0;
      end
      prev_en   = mem_en;
      prev_addr = mem_addr;
      prev_wr   = mem_wr_en;
      prev_wd   = mem_wr_data;
    end
  end

  // Scoreboard: every accepted response is compared against exp_q in order.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      check("resp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        check("resp_rdata", 32'(resp_rdata), 32'(exp_v[7:0]));
        check("resp_err", 32'(resp_err), 32'(exp_v[8]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [5:0] addr, input logic [7:0] wd,
                          input bit keep);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    for (int i = 0; i < 400 && !cmd_ready; i++) step();
    check("cmd_accept_wait", 32'(cmd_ready), 1);
    step();
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    check(tag, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_wr     = 1'b0;
    cmd_addr   = 6'h00;
    cmd_wdata  = 8'h00;
    resp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_outputs", 32'({mem_wr_en, mem_addr, mem_wr_data, resp_rdata, resp_err}), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    #20 rst_n = 1'b1;
    step();
    check("idle_cmd_ready", 32'(cmd_ready), 1);

    // write 0xA5 to 0x2A, then read it back
    exp_q.push_back({1'b0, 8'h00});
    send_cmd(1'b1, 6'h2A, 8'hA5, 1'b0);
    check("req_state", 32'(dbg_state), 32'(S_REQ));
    check("req_mem_en", 32'(mem_en), 1);
    check("req_mem_addr", 32'(mem_addr), 32'h2A);
    exp_q.push_back({1'b0, 8'hA5});
    send_cmd(1'b0, 6'h2A, 8'h00, 1'b0);
    drain("drain_wr_rd");

    // two reads with cmd_valid held high throughout
    exp_q.push_back({1'b0, 8'h3C});
    exp_q.push_back({1'b0, 8'hC3});
    send_cmd(1'b0, 6'h01, 8'h00, 1'b1);
    send_cmd(1'b0, 6'h02, 8'h00, 1'b0);
    drain("drain_b2b");

    // responder disconnected: timeout after exactly 16 cycles of mem_en
    rsp_on = 1'b0;
    exp_q.push_back({1'b1, 8'h00});
    send_cmd(1'b0, 6'h05, 8'h00, 1'b0);
    drain("drain_timeout");
    check("timeout_en_len", 32'(last_en_len), 16);
    rsp_on = 1'b1;
    exp_q.push_back({1'b0, 8'hC3});
    send_cmd(1'b0, 6'h02, 8'h00, 1'b0);
    drain("drain_reconnect");

    // response held off for 5 cycles, accepted in the 6th
    resp_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h00});
    send_cmd(1'b1, 6'h10, 8'h77, 1'b0);
    for (int i = 0; i < 400 && !resp_valid; i++) step();
    for (int k = 0; k < 5; k++) begin
      check("hold_resp_valid", 32'(resp_valid), 1);
      check("hold_resp_data", 32'({resp_err, resp_rdata}), 0);
      check("hold_cmd_ready", 32'(cmd_ready), 0);
      step();
    end
    resp_ready = 1'b1;
    step();
    check("accept_resp_valid", 32'(resp_valid), 0);
    check("accept_cmd_ready", 32'(cmd_ready), 1);
    check("accept_state", 32'(dbg_state), 32'(S_IDLE));
    check("hold_q_empty", 32'(exp_q.size()), 0);

    // completion on the last counted cycle wins over the timeout
    rsp_delay = 15;
    exp_q.push_back({1'b0, 8'h3C});
    send_cmd(1'b0, 6'h01, 8'h00, 1'b0);
    drain("drain_edge_ok");
    check("edge_ok_en_len", 32'(last_en_len), 16);
    // one cycle later is a timeout
    rsp_delay = 16;
    exp_q.push_back({1'b1, 8'h00});
    send_cmd(1'b0, 6'h01, 8'h00, 1'b0);
    drain("drain_edge_tmo");
    check("edge_tmo_en_len", 32'(last_en_len), 16);
    rsp_delay = 8;

    // asynchronous reset in the middle of an access
    send_cmd(1'b0, 6'h03, 8'h00, 1'b0);
    step();
    step();
    check("mid_req_en", 32'(mem_en), 1);
    check("mid_req_state", 32'(dbg_state), 32'(S_REQ));
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_en", 32'(mem_en), 0);
    check("async_resp_valid", 32'(resp_valid), 0);
    check("async_cmd_ready", 32'(cmd_ready), 0);
    check("async_state", 32'(dbg_state), 32'(S_IDLE));
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    exp_q.push_back({1'b0, 8'h5A});
    send_cmd(1'b0, 6'h00, 8'h00, 1'b0);
    drain("drain_post_rst");

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
